// File: rtl/serial_subtractor_32bit.sv
// ---------------------------------------------------------------------------
// serial_subtractor_32bit
//
// Bit-serial subtractor. It computes diff = (a - b - bin) mod 2^WIDTH one bit
// per clock, LSB first, and also produces the unsigned borrow-out and the
// two's-complement overflow flag. Operands are taken with a valid/ready
// handshake and the result is returned with a valid/ready handshake.
//
// Sequence: IDLE (accept) -> RUN (WIDTH cycles) -> DONE (hold until taken).
//
// Ports
//   clk        clock, rising edge active
//   rst        synchronous active-high reset
//   in_valid   operands a/b/bin are presented this cycle
//   in_ready   block is idle and accepts operands
//   a, b, bin  minuend, subtrahend, borrow-in
//   out_valid  diff/bout/ovf hold a finished result
//   out_ready  consumer takes the result this cycle
//   diff       (a - b - bin) mod 2^WIDTH
//   bout       1 when unsigned a < b + bin
//   ovf        signed overflow of a - b - bin
// ---------------------------------------------------------------------------
module serial_subtractor_32bit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             br_r;
   logic [WIDTH-1:0] res_r;
   logic [WIDTH-1:0] diff_r;
   logic             bout_r;
   logic             ovf_r;

   logic             bit_a_s;
   logic             bit_b_s;
   logic             d_s;
   logic             br_next_s;
   logic             in_ready_s;
   logic             out_valid_s;

   // One-bit full-subtractor slice on the bit selected by the counter.
   always_comb begin
      bit_a_s   = a_r[cnt_r];
      bit_b_s   = b_r[cnt_r];
      d_s       = bit_a_s ^ bit_b_s ^ br_r;
      br_next_s = (~bit_a_s & bit_b_s) | (~(bit_a_s ^ bit_b_s) & br_r);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state and handshake decode.
   always_comb begin
      state_s     = state_r;
      in_ready_s  = 1'b0;
      out_valid_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            in_ready_s = 1'b1;
            if (in_valid) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (cnt_r == LAST_BIT) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_DONE: begin
            out_valid_s = 1'b1;
            if (out_ready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Operand capture, serial datapath and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r  <= {CW{1'b0}};
         a_r    <= {WIDTH{1'b0}};
         b_r    <= {WIDTH{1'b0}};
         br_r   <= 1'b0;
         res_r  <= {WIDTH{1'b0}};
         diff_r <= {WIDTH{1'b0}};
         bout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  a_r   <= a;
                  b_r   <= b;
                  br_r  <= bin;
                  cnt_r <= {CW{1'b0}};
                  res_r <= {WIDTH{1'b0}};
               end
            end
            ST_RUN: begin
               // Result bits enter at the MSB and shift down, so after WIDTH
               // steps bit 0 has reached position 0.
               res_r <= {d_s, res_r[WIDTH-1:1]};
               br_r  <= br_next_s;
               cnt_r <= cnt_r + CW'(1);
               if (cnt_r == LAST_BIT) begin
                  diff_r <= {d_s, res_r[WIDTH-1:1]};
                  bout_r <= br_next_s;
                  // d_s is the sign bit of the result on this last step.
                  ovf_r  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (d_s != a_r[WIDTH-1]);
               end
            end
            ST_DONE: begin
               cnt_r <= cnt_r;
            end
            default: begin
               cnt_r <= {CW{1'b0}};
            end
         endcase
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_s;
   assign diff      = diff_r;
   assign bout      = bout_r;
   assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_subtractor_32bit.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor_32bit
//
// Scoreboard bench. The driver pushes the arithmetic expectation of every
// accepted operation into a queue; an independent monitor pops and compares
// whenever the DUT hands a result over, and also checks result latency.
// ---------------------------------------------------------------------------
module tb_serial_subtractor_32bit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = 32'h0;
   logic [31:0] b = 32'h0;
   logic        bin = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] diff;
   logic        bout;
   logic        ovf;

   typedef struct {
      logic [31:0] d;
      logic        bo;
      logic        ov;
      int          acc;
   } exp_t;

   exp_t sbq[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   logic prev_ov = 1'b0;
   logic rand_ready = 1'b0;

   serial_subtractor_32bit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .bout(bout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   // Random consumer backpressure when enabled.
   always @(posedge clk) begin
      if (rand_ready) begin
         #1 out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Reference: plain 33-bit unsigned and 64-bit signed arithmetic.
   function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb_, input logic tbin);
      exp_t        e;
      logic [32:0] full;
      longint      sd;
      full = {1'b0, ta} - {1'b0, tb_} - {32'h0, tbin};
      sd   = longint'($signed(ta)) - longint'($signed(tb_)) - longint'(tbin);
      e.d  = full[31:0];
      e.bo = full[32];
      e.ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      e.acc = 0;
      return e;
   endfunction

   // Monitor: latency on each new result, value compare on each handover.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && !prev_ov) begin
            if (sbq.size() > 0) chk("latency", 64'(cyc - sbq[0].acc), 64'd32);
            else chk("unexpected_valid", 64'(out_valid), 64'd0);
         end
         if (out_valid && out_ready) begin
            if (sbq.size() > 0) begin
               exp_t e;
               e = sbq.pop_front();
               chk("diff", 64'(diff), 64'(e.d));
               chk("bout", 64'(bout), 64'(e.bo));
               chk("ovf",  64'(ovf),  64'(e.ov));
            end else begin
               chk("unexpected_result", 64'(out_valid), 64'd0);
            end
         end
      end
      prev_ov = out_valid;
   end

   task automatic send(input logic [31:0] ta, input logic [31:0] tb_, input logic tbin);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
      a = ta; b = tb_; bin = tbin; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      e = model(ta, tb_, tbin);
      e.acc = cyc;
      sbq.push_back(e);
      a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() > 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", 64'(sbq.size()), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] hd;
      logic        hb, ho;
      int          seen;
      logic [31:0] corner [6];
      corner[0] = 32'h0000_0000; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'h8000_0000;
      corner[3] = 32'h7FFF_FFFF; corner[4] = 32'h0000_0001; corner[5] = 32'h8000_0001;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_diff", 64'(diff), 64'd0);
      chk("rst_bout_ovf", 64'({bout, ovf}), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Directed vectors including wrap and 33-bit borrow boundaries.
      send(32'h0000_0005, 32'h0000_0003, 1'b0);
      send(32'h0000_0000, 32'h0000_0001, 1'b0);
      send(32'h8000_0000, 32'h0000_0001, 1'b0);
      send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      send(32'h1234_5678, 32'h1234_5678, 1'b1);
      send(32'h0000_0000, 32'h0000_0000, 1'b1);
      send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      send(32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
      drain();

      // Backpressure with ignored in_valid pulses during RUN and DONE.
      out_ready = 1'b0;
      send(32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1);
      repeat (3) begin
         @(negedge clk);
         in_valid = 1'b1; a = $urandom; b = $urandom;
         @(posedge clk);
         #1 in_valid = 1'b0;
      end
      wait_valid();
      hd = diff; hb = bout; ho = ovf;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", 64'(out_valid), 64'd1);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_hold", 64'({diff, bout, ovf}), 64'({hd, hb, ho}));
         in_valid = 1'b1; a = $urandom; b = $urandom;
         @(posedge clk);
         #1 in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_release_in_ready", 64'(in_ready), 64'd1);
      chk("bp_release_out_valid", 64'(out_valid), 64'd0);
      drain();

      // Reset abort with the counter at 10.
      send(32'h5555_AAAA, 32'h0F0F_0F0F, 1'b0);
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      sbq.delete();
      @(negedge clk);
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_diff", 64'(diff), 64'd0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("abort_no_result", 64'(seen), 64'd0);
      send(32'h0000_000A, 32'h0000_0004, 1'b0);
      drain();

      // Randomized operations with random consumer backpressure.
      rand_ready = 1'b1;
      for (int i = 0; i < 24; i++) begin
         logic [31:0] ra, rb;
         ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
         send(ra, rb, 1'($urandom_range(0, 1)));
         if (i % 4 == 0) begin
            @(negedge clk);
            in_valid = 1'b1;
            @(posedge clk);
            #1 in_valid = 1'b0;
         end
      end
      drain();
      rand_ready = 1'b0;
      @(posedge clk);
      #2 out_ready = 1'b1;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
